// File: rtl/ai_accel_pkg.sv
// Shared constants, FSM state type and saturation helper for the matrix-vector engine.
package ai_accel_pkg;

  localparam logic [3:0] REGION_CTRL = 4'h0;
  localparam logic [3:0] REGION_ACT  = 4'h1;
  localparam logic [3:0] REGION_RES  = 4'h2;
  localparam logic [3:0] REGION_WGT  = 4'h8;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_LEN    = 4'd2;
  localparam logic [3:0] OFF_BASE   = 4'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  localparam int LEN_W  = 13;
  localparam int BASE_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Caller sign-extends the accumulator to 64 bits and keeps the low bus_w bits.
  function automatic logic signed [63:0] sat_to_bus(input logic signed [63:0] v,
                                                    input int bus_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bus_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bus_w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/ai_mac_lane.sv
// One MAC channel: weight memory, registered operand read, signed multiply-accumulate
// and a saturated view of the accumulator.
module ai_mac_lane
  import ai_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 32,
  parameter int DEPTH      = 1024,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(DEPTH),
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                raddr,
  input  logic                         issue,
  input  logic                         acc_clr,
  input  logic                         mac_en,
  input  logic signed [DATA_WIDTH-1:0] act,
  output logic signed [DATA_WIDTH-1:0] rdata,
  output logic [BUS_WIDTH-1:0]         result
);

  logic signed [DATA_WIDTH-1:0]   mem [DEPTH];
  logic signed [DATA_WIDTH-1:0]   w_q;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc;

  // Weight contents survive reset; only the datapath registers clear.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Single read port: engine address while running, host offset otherwise.
  assign rdata = mem[raddr];
  assign prod  = act * w_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_q <= '0;
      acc <= '0;
    end else begin
      if (issue) w_q <= rdata;
      if (acc_clr) acc <= '0;
      else if (mac_en) acc <= acc + ACC_WIDTH'(prod);
    end
  end

  assign result = BUS_WIDTH'(sat_to_bus(64'(acc), BUS_WIDTH));

endmodule

// File: rtl/ai_mvm_engine.sv
// Memory-mapped matrix-vector multiply engine: host bus decode, control FSM,
// activation memory and NUM_CH parallel MAC lanes.
module ai_mvm_engine
  import ai_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 1024,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0]  data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [BUS_WIDTH-1:0]  data_out,
  output logic                  read_valid,
  output logic                  ready,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  region;
  logic [11:0] off;
  logic        off_in_mem;
  assign region     = addr[15:12];
  assign off        = addr[11:0];
  assign off_in_mem = ({1'b0, off} < 13'(DEPTH));

  state_t              state;
  logic                busy_q, done_q, err_q, ready_q, issue_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [BASE_W-1:0]   base_q;
  logic [AW-1:0]       idx_q;
  logic                issue, acc_clr;
  logic                ctrl_sel, ctrl_wr, host_wr_ok, start_req, clr_req, range_ok;

  assign issue      = (state == RUN);
  assign acc_clr    = (state == CLEAR);
  assign ctrl_sel   = (region == REGION_CTRL);
  assign ctrl_wr    = write_enable && ctrl_sel && (off[3:0] == OFF_CTRL);
  assign host_wr_ok = write_enable && !busy_q;
  assign start_req  = ctrl_wr && data_in[CTRL_START_BIT];
  assign clr_req    = ctrl_wr && data_in[CTRL_CLR_BIT];
  assign range_ok   = (len_q != '0) &&
                      (({2'b00, base_q} + {1'b0, len_q}) <= 14'(DEPTH));

  // A clear in the same write as START is overridden by the START outcome below.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      issue_q <= 1'b0;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      issue_q <= issue;
      if (clr_req) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (host_wr_ok && ctrl_sel && off[3:0] == OFF_LEN)  len_q  <= data_in[LEN_W-1:0];
      if (host_wr_ok && ctrl_sel && off[3:0] == OFF_BASE) base_q <= data_in[BASE_W-1:0];
      case (state)
        IDLE: begin
          if (start_req) begin
            if (range_ok) begin
              state   <= CLEAR;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          idx_q <= base_q[AW-1:0];
          cnt_q <= len_q;
          state <= RUN;
        end
        RUN: begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [DATA_WIDTH-1:0] act_mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] act_q;
  logic                         act_we;
  assign act_we = host_wr_ok && (region == REGION_ACT) && off_in_mem;

  always_ff @(posedge clk) begin
    if (act_we) act_mem[off[AW-1:0]] <= data_in[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) act_q <= '0;
    else if (issue) act_q <= act_mem[idx_q];
  end

  logic signed [DATA_WIDTH-1:0] lane_rdata  [NUM_CH];
  logic [BUS_WIDTH-1:0]         lane_result [NUM_CH];
  logic [AW-1:0]                lane_raddr;
  assign lane_raddr = issue ? idx_q : off[AW-1:0];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    logic we;
    assign we = host_wr_ok && (region == (REGION_WGT + 4'(ch))) && off_in_mem;
    ai_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .BUS_WIDTH (BUS_WIDTH),
      .DEPTH     (DEPTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .waddr  (off[AW-1:0]),
      .wdata  (data_in[DATA_WIDTH-1:0]),
      .raddr  (lane_raddr),
      .issue  (issue),
      .acc_clr(acc_clr),
      .mac_en (issue_q),
      .act    (act_q),
      .rdata  (lane_rdata[ch]),
      .result (lane_result[ch])
    );
  end

  // Memories are not readable while busy; results give the live accumulator.
  logic [BUS_WIDTH-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (region)
      REGION_CTRL: begin
        case (off[3:0])
          OFF_STATUS: rd_mux = BUS_WIDTH'({err_q, done_q, busy_q});
          OFF_LEN:    rd_mux = BUS_WIDTH'(len_q);
          OFF_BASE:   rd_mux = BUS_WIDTH'(base_q);
          default:    rd_mux = '0;
        endcase
      end
      REGION_ACT: begin
        if (!busy_q && off_in_mem) rd_mux = BUS_WIDTH'(act_mem[off[AW-1:0]]);
      end
      REGION_RES: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (off == 12'(ch)) rd_mux = lane_result[ch];
        end
      end
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (region == (REGION_WGT + 4'(ch)) && !busy_q && off_in_mem)
            rd_mux = BUS_WIDTH'(lane_rdata[ch]);
        end
      end
    endcase
  end

  // Read handshake: read_enable sampled at an edge gives read_valid high for exactly
  // the following cycle with data_out holding the pre-write value of that address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) data_out <= rd_mux;
    end
  end

  assign ready = ready_q;
  assign irq   = done_q;

  logic unused_bits;
  assign unused_bits = ^data_in[BUS_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_ai_mvm_engine.sv
// Self-checking bench for ai_mvm_engine: bus driver tasks, read scoreboard, reference model.
module tb_ai_mvm_engine;

  localparam int DEP = 1024;
  localparam int NCH = 4;
  localparam logic [15:0] A_CTRL   = 16'h0000;
  localparam logic [15:0] A_STATUS = 16'h0001;
  localparam logic [15:0] A_LEN    = 16'h0002;
  localparam logic [15:0] A_BASE   = 16'h0003;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] data_in = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] data_out;
  logic        read_valid, ready, irq;

  ai_mvm_engine dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .data_in     (data_in),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .data_out    (data_out),
    .read_valid  (read_valid),
    .ready       (ready),
    .irq         (irq)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          act_m [DEP];
  int          w_m [NCH][DEP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && read_valid) begin
      if (exp_q.size() == 0) check("unexpected_read_valid", {31'b0, read_valid}, 32'd0);
      else check(tag_q.pop_front(), data_out, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] model_result(input int ch, input int base, input int len);
    longint s = 0;
    for (int i = 0; i < len; i++) s += longint'(act_m[base + i]) * longint'(w_m[ch][base + i]);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return 32'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; data_in = d; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
    addr = a; read_enable = 1'b1;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(posedge clk); #1;
    read_enable = 1'b0;
  endtask

  task automatic bus_rw(input logic [15:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input string tag);
    addr = a; data_in = d; write_enable = 1'b1; read_enable = 1'b1;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(posedge clk); #1;
    write_enable = 1'b0; read_enable = 1'b0;
  endtask

  // Upper data bits carry junk to confirm only the low element bits are stored.
  task automatic wr_act(input int i, input int v);
    logic signed [15:0] v16;
    v16 = 16'(v);
    act_m[i] = int'(v16);
    bus_write({4'h1, 12'(i)}, {16'($urandom), v16});
  endtask

  task automatic wr_w(input int ch, input int i, input int v);
    logic signed [15:0] v16;
    v16 = 16'(v);
    w_m[ch][i] = int'(v16);
    bus_write({4'(8 + ch), 12'(i)}, {16'($urandom), v16});
  endtask

  task automatic read_results(input int base, input int len, input string tag);
    for (int ch = 0; ch < NCH; ch++)
      bus_read({4'h2, 12'(ch)}, model_result(ch, base, len), $sformatf("%s_res%0d", tag, ch));
  endtask

  // START with exact latency checks: busy through cycle LEN+2, done in cycle LEN+3.
  task automatic run_and_wait(input int len, input string tag);
    bus_write(A_CTRL, 32'h1);
    check({tag, "_ready_c1"}, {31'b0, ready}, 32'd0);
    repeat (len + 1) @(posedge clk);
    #1;
    check({tag, "_ready_before_done"}, {31'b0, ready}, 32'd0);
    check({tag, "_irq_before_done"}, {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready_done"}, {31'b0, ready}, 32'd1);
    check({tag, "_irq_done"}, {31'b0, irq}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_in_budget"}, {31'b0, ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 32'd0);
    check("rst_read_valid", {31'b0, read_valid}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b1;
    bus_read(A_STATUS, 32'd0, "rst_status");
    bus_read(A_LEN, 32'd0, "rst_len");
    bus_read(A_BASE, 32'd0, "rst_base");

    // Basic run over four elements.
    for (int i = 0; i < 4; i++) begin
      wr_act(i, i + 1);
      wr_w(0, i, 1);
      wr_w(1, i, -(i + 1));
      wr_w(2, i, int'($urandom_range(2000)) - 1000);
      wr_w(3, i, int'($urandom_range(2000)) - 1000);
    end
    bus_write(A_LEN, 32'd4);
    bus_write(A_BASE, 32'd0);
    bus_read(A_LEN, 32'd4, "len_rb");
    run_and_wait(4, "basic");
    bus_read(A_STATUS, 32'h2, "basic_status");
    bus_read({4'h2, 12'd0}, 32'd10, "basic_res0_const");
    bus_read({4'h2, 12'd1}, 32'hFFFF_FFE2, "basic_res1_const");
    read_results(0, 4, "basic");
    bus_read({4'h1, 12'd0}, 32'd1, "act0_rb");
    bus_read({4'h9, 12'd0}, 32'hFFFF_FFFF, "w1_0_sext");
    bus_read(16'h4000, 32'd0, "unmapped_rd");
    bus_read(A_CTRL, 32'd0, "ctrl_rd_zero");
    wr_act(5, 7);
    bus_rw({4'h1, 12'd5}, 32'd9, 32'd7, "rw_prewrite");
    bus_read({4'h1, 12'd5}, 32'd9, "rw_postwrite");
    act_m[5] = 9;

    // Top of memory, then one element past it.
    for (int i = 1020; i < 1024; i++) begin
      wr_act(i, int'($urandom_range(60000)) - 30000);
      for (int ch = 0; ch < NCH; ch++) wr_w(ch, i, int'($urandom_range(60000)) - 30000);
    end
    bus_write(A_BASE, 32'd1020);
    run_and_wait(4, "top");
    read_results(1020, 4, "top");
    bus_write(A_BASE, 32'd1021);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, 32'h6, "oob_status");
    check("oob_ready", {31'b0, ready}, 32'd1);
    read_results(1020, 4, "oob_unchanged");

    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, 32'h0, "clr_status");
    check("clr_irq", {31'b0, irq}, 32'd0);

    bus_write(A_LEN, 32'd0);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, 32'h6, "len0_status");
    check("len0_irq", {31'b0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h2);

    // Host writes and START while busy are dropped.
    bus_write(A_LEN, 32'd4);
    bus_write(A_BASE, 32'd0);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, 32'h1, "busy_status");
    bus_write({4'h1, 12'd0}, 32'd99);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_LEN, 32'd1);
    wait_done(20, "busy");
    repeat (5) @(posedge clk);
    #1;
    check("busy_single_run", {31'b0, ready}, 32'd1);
    bus_read({4'h1, 12'd0}, 32'd1, "busy_act0_kept");
    bus_read(A_LEN, 32'd4, "busy_len_kept");
    read_results(0, 4, "busy");

    // Full-length run driving both saturation limits.
    for (int i = 0; i < DEP; i++) begin
      wr_act(i, 32'h7FFF);
      wr_w(0, i, 32'h7FFF);
      wr_w(1, i, -32768);
    end
    bus_write(A_LEN, 32'd1024);
    bus_write(A_CTRL, 32'h1);
    wait_done(1100, "sat");
    bus_read({4'h2, 12'd0}, 32'h7FFF_FFFF, "sat_pos");
    bus_read({4'h2, 12'd1}, 32'h8000_0000, "sat_neg");
    bus_read(A_STATUS, 32'h2, "sat_status");

    // Reset in the middle of a run, then a clean rerun.
    for (int i = 0; i < 4; i++) wr_act(i, i + 1);
    bus_write(A_LEN, 32'd4);
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    bus_read(A_STATUS, 32'h0, "midrst_status");
    bus_read(A_LEN, 32'h0, "midrst_len");
    bus_read({4'h2, 12'd0}, 32'd0, "midrst_res0");
    bus_write(A_LEN, 32'd4);
    run_and_wait(4, "rerun");
    bus_read({4'h2, 12'd0}, model_result(0, 0, 4), "rerun_res0");

    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_mvm_engine.md
Name: ai_mvm_engine

Overview:
- Memory-mapped matrix-vector multiply engine; successor to the single-bus accelerator top.
- Host loads an activation vector and NUM_CH weight rows over the existing addr/data bus, programs LEN/BASE, then writes START.
- Runs NUM_CH parallel signed MAC lanes, one element per cycle, and exposes saturated per-channel results plus busy/done/error status.

Parameters:
- DATA_WIDTH, 16, signed element width of activations and weights.
- BUS_WIDTH, 32, host data bus width and result readback width.
- ADDR_WIDTH, 16, host address width.
- NUM_CH, 4, parallel channels (weight rows / MAC lanes), 1..8.
- DEPTH, 1024, elements per vector memory, power of 2, at most 4096.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(DEPTH), accumulator width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- addr  in  ADDR_WIDTH  host address.
- data_in  in  BUS_WIDTH  host write data.
- write_enable  in  1  host write strobe.
- read_enable  in  1  host read strobe.
- data_out  out  BUS_WIDTH  registered read data.
- read_valid  out  1  data_out valid; asserts exactly one cycle after read_enable.
- ready  out  1  engine idle (not busy).
- irq  out  1  level, equals STATUS.done.

Behaviour:
- Address map: addr[15:12] selects the region; addr[11:0] is the offset.
  - 0x0: control registers, offset[3:0].
  - 0x1: activation memory.
  - 0x2: results, offset = channel.
  - 0x8+ch: weight memory for channel ch.
  - Unmapped reads return 0; unmapped writes are dropped.
- Control registers:
  - 0 CTRL (write-only): bit0 START, bit1 CLR_DONE. Reads return 0.
  - 1 STATUS (read-only): bit0 busy, bit1 done, bit2 error.
  - 2 LEN (R/W): 13 bits.
  - 3 BASE (R/W): 12 bits.
- Memory writes take the low DATA_WIDTH bits of data_in. Memory reads sign-extend to BUS_WIDTH.
- Reset (reset==0 at a clock edge): outputs and registers clear.
  - data_out=0, read_valid=0, ready=1, irq=0.
  - LEN=0, BASE=0, status=0, FSM in IDLE, accumulators=0.
  - Memory contents are not reset.
- FSM states: IDLE, CLEAR, RUN, DRAIN.
  - IDLE + START with LEN!=0 and BASE+LEN<=DEPTH: go to CLEAR; done and error clear.
  - IDLE + START with LEN==0 or BASE+LEN>DEPTH: stay in IDLE; done=1, error=1 next cycle; accumulators untouched.
  - CLEAR: zero all accumulators; idx=BASE; go to RUN.
  - RUN: issue a read of act[idx] and w_ch[idx] for all ch, idx++. After LEN issues, go to DRAIN.
  - MAC stage is one cycle after each read: acc_ch += act*w_ch (signed, full ACC_WIDTH, wraps on overflow).
  - DRAIN: final MAC completes; go to IDLE; done=1.
- Latency: START write in cycle 0.
  - busy=1 and ready=0 from cycle 1.
  - done=1, busy=0 and ready=1 in cycle LEN+3.
- Result read: acc_ch saturated to signed BUS_WIDTH, clamped to 0x7FFFFFFF or 0x80000000.
  - Reads while busy return the live, partial value.
- While busy:
  - START is ignored.
  - Host writes to activation, weight, LEN and BASE are dropped.
  - Control and status reads are permitted.
- CLR_DONE clears done and error. If CLR_DONE and START are written together, the clear applies first, then START.
- write_enable and read_enable in the same cycle are both serviced; the read returns the pre-write value.
- Reset mid-RUN aborts to IDLE with all state cleared.

Decomposition:
- Package ai_accel_pkg holds:
  - Region constants and control-register offsets.
  - STATUS bit indices.
  - state_t enum (IDLE, CLEAR, RUN, DRAIN).
  - Function sat_to_bus() for ACC_WIDTH to BUS_WIDTH signed saturation.
- Sub-module ai_mac_lane, one per channel via generate:
  - Weight memory (1 write port, 1 read port), registered read, signed multiplier, accumulator with clear/enable.
  - Saturated result output.

Test Plan:
- act[0..3]={1,2,3,4}; w0={1,1,1,1}; w1={-1,-2,-3,-4}; LEN=4, BASE=0; START -> done in cycle 7; result0=10, result1=-30; irq=1; ready=1.
- BASE=1020, LEN=4, DEPTH=1024 -> valid run over the top four elements; BASE=1021, LEN=4 -> next cycle STATUS=0b110, no busy, results unchanged.
- LEN=0, START -> error=1, done=1. Write CTRL=0x2 -> STATUS=0, irq=0.
- DATA_WIDTH=16, act=w0=0x7FFF ×1024, LEN=1024 -> result0 reads 0x7FFFFFFF (saturated); STATUS.error=0.
- During RUN: write act[0]=99, write START, write LEN=1 -> all ignored; readback of act[0] and LEN after done shows old values; one run only.
- reset asserted mid-RUN for one cycle -> next cycle STATUS=0, ready=1, result0=0. A new START then completes with the correct result.
